// File: rtl/bec_ladder_ctrl_if.sv
// Host and datapath bundle for the binary-Edwards-curve ladder controller.
// The master side is the environment; the slave side is the controller.
interface bec_ladder_ctrl_if #(
    parameter int unsigned W = 163
);
    logic         start;
    logic [W-1:0] key;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   op_idx;
    logic [W-1:0] op_data;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] res_x;
    logic [W-1:0] res_z;
    logic         bec_load_data;
    logic         bec_trig_load;
    logic [2:0]   bec_load_status;
    logic [W-1:0] bec_data_in;
    logic         bec_ki;
    logic         bec_enable;
    logic         bec_next_key;
    logic [3:0]   bec_status;
    logic         bec_done;
    logic [W-1:0] bec_data_out;

    modport master (
        output start, key, op_valid, op_data,
        output bec_next_key, bec_status, bec_done, bec_data_out,
        input  op_ready, op_idx, busy, done, err, res_x, res_z,
        input  bec_load_data, bec_trig_load, bec_load_status,
        input  bec_data_in, bec_ki, bec_enable
    );

    modport slave (
        input  start, key, op_valid, op_data,
        input  bec_next_key, bec_status, bec_done, bec_data_out,
        output op_ready, op_idx, busy, done, err, res_x, res_z,
        output bec_load_data, bec_trig_load, bec_load_status,
        output bec_data_in, bec_ki, bec_enable
    );
endinterface

// File: rtl/bec_ladder_ctrl.sv
// Sequencer for the lovers_bec ladder datapath: loads six operands,
// feeds the scalar MSB-first, watchdogs the run and unloads both results.
module bec_ladder_ctrl #(
    parameter int unsigned W         = 163,
    parameter int unsigned KEY_ITERS = 163,
    parameter logic [31:0] TIMEOUT   = 32'd2000000
) (
    input logic             clk,
    input logic             rst,
    bec_ladder_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, REQ, OPW, TRIG, ENA, RUN, UPA, UPB, FIN
    } state_e;

    localparam logic [7:0]  ITERS8  = 8'(KEY_ITERS);
    localparam logic [31:0] WD_LAST = TIMEOUT - 32'd1;

    state_e       state_q;
    logic [W-1:0] key_q;
    logic [W-1:0] data_in_q;
    logic [W-1:0] res_x_q;
    logic [W-1:0] res_z_q;
    logic [7:0]   iter_q;
    logic [7:0]   iter_d;
    logic [31:0]  wd_q;
    logic [2:0]   op_idx_q;
    logic [2:0]   load_status_q;
    logic         busy_q;
    logic         done_q;
    logic         err_q;
    logic         op_ready_q;
    logic         load_data_q;
    logic         trig_q;
    logic         enable_q;

    // Saturating count; includes a key pulse coincident with bec_done.
    always_comb begin
        iter_d = iter_q;
        if (bus.bec_next_key && iter_q != 8'hFF) begin
            iter_d = iter_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            key_q         <= '0;
            data_in_q     <= '0;
            res_x_q       <= '0;
            res_z_q       <= '0;
            iter_q        <= '0;
            wd_q          <= '0;
            op_idx_q      <= '0;
            load_status_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            op_ready_q    <= 1'b0;
            load_data_q   <= 1'b0;
            trig_q        <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            trig_q   <= 1'b0;
            enable_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        key_q       <= bus.key;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        iter_q      <= '0;
                        load_data_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (bus.bec_status[2]) begin
                        load_data_q <= 1'b0;
                        op_ready_q  <= 1'b1;
                        op_idx_q    <= '0;
                        state_q     <= OPW;
                    end
                end
                OPW: begin
                    if (bus.op_valid && op_ready_q) begin
                        data_in_q     <= bus.op_data;
                        load_status_q <= op_idx_q;
                        trig_q        <= 1'b1;
                        op_ready_q    <= 1'b0;
                        state_q       <= TRIG;
                    end
                end
                TRIG: begin
                    if (op_idx_q == 3'd5) begin
                        enable_q <= 1'b1;
                        wd_q     <= '0;
                        state_q  <= ENA;
                    end else begin
                        op_idx_q   <= op_idx_q + 3'd1;
                        op_ready_q <= 1'b1;
                        state_q    <= OPW;
                    end
                end
                ENA: state_q <= RUN;
                RUN: begin
                    wd_q   <= wd_q + 32'd1;
                    iter_q <= iter_d;
                    if (bus.bec_next_key) begin
                        key_q <= key_q << 1;
                    end
                    if (bus.bec_done) begin
                        if (iter_d != ITERS8) begin
                            err_q <= 1'b1;
                        end
                        load_status_q <= 3'd0;
                        state_q       <= UPA;
                    end else if (wd_q == WD_LAST) begin
                        // Datapath is left mid-run; only rst recovers it.
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                UPA: begin
                    res_x_q       <= bus.bec_data_out;
                    load_status_q <= 3'd1;
                    state_q       <= UPB;
                end
                UPB: begin
                    res_z_q <= bus.bec_data_out;
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                FIN: begin
                    busy_q        <= 1'b0;
                    load_status_q <= 3'd0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.op_ready        = op_ready_q;
    assign bus.op_idx          = op_idx_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.err             = err_q;
    assign bus.res_x           = res_x_q;
    assign bus.res_z           = res_z_q;
    assign bus.bec_load_data   = load_data_q;
    assign bus.bec_trig_load   = trig_q;
    assign bus.bec_load_status = load_status_q;
    assign bus.bec_data_in     = data_in_q;
    assign bus.bec_ki          = key_q[W-1];
    assign bus.bec_enable      = enable_q;
endmodule

// File: tb/tb_bec_ladder_ctrl.sv
// Randomised scoreboard bench for bec_ladder_ctrl with a behavioural
// ladder datapath and a short-watchdog second instance.
module tb_bec_ladder_ctrl;
    localparam int W = 163;
    localparam int KEY_ITERS = 163;

    typedef struct {
        logic [2:0]   idx;
        logic [W-1:0] d;
        logic         ki;
    } trig_t;

    typedef struct {
        logic         err;
        logic [W-1:0] x;
        logic [W-1:0] z;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bec_ladder_ctrl_if #(.W(W)) bus ();
    bec_ladder_ctrl_if #(.W(W)) bus2 ();

    bec_ladder_ctrl #(.W(W), .KEY_ITERS(KEY_ITERS)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    bec_ladder_ctrl #(.W(W), .KEY_ITERS(KEY_ITERS), .TIMEOUT(32'd64)) u_wd (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    trig_t trig_q[$];
    res_t  res_q[$];

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void chki(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Behavioural datapath: idle -> download -> proc -> upload.
    int           n_tgt = KEY_ITERS;
    bit           coin = 1'b0;
    int           mst;
    int           pulses;
    int           cnt_after;
    logic         nk;
    logic         dn;
    logic         rbit;
    logic         nxt;
    logic [W-1:0] kb;
    logic [W-1:0] mops [6];
    logic [W-1:0] reg_a;
    logic [W-1:0] reg_b;

    assign cnt_after = pulses + int'(nk);
    assign nxt = (cnt_after < n_tgt) &&
                 (rbit || (coin && cnt_after + 1 == n_tgt));
    assign reg_a = mops[0] ^ mops[1] ^ mops[2] ^ kb;
    assign reg_b = mops[3] ^ mops[4] ^ mops[5] ^ ~kb;

    assign bus.bec_status   = {mst == 0, mst == 1, mst == 2, mst == 3};
    assign bus.bec_next_key = nk;
    assign bus.bec_done     = dn;
    assign bus.bec_data_out = (mst != 3) ? '0 :
                              (bus.bec_load_status == 3'd0) ? reg_a : reg_b;

    always @(posedge clk) rbit <= 1'($urandom_range(0, 2) != 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mst    <= 0;
            nk     <= 1'b0;
            dn     <= 1'b0;
            pulses <= 0;
            kb     <= '0;
        end else begin
            if (nk) begin
                kb     <= {kb[W-2:0], bus.bec_ki};
                pulses <= pulses + 1;
            end
            case (mst)
                0: if (bus.bec_load_data) mst <= 1;
                1: begin
                    if (bus.bec_trig_load && bus.bec_load_status < 3'd6)
                        mops[bus.bec_load_status] <= bus.bec_data_in;
                    if (bus.bec_enable) begin
                        mst    <= 2;
                        pulses <= 0;
                        kb     <= '0;
                        nk     <= rbit;
                    end
                end
                2: begin
                    nk <= nxt;
                    if (cnt_after == n_tgt || (coin && nxt && cnt_after + 1 == n_tgt)) begin
                        dn  <= 1'b1;
                        mst <= 3;
                    end
                end
                default: begin
                    nk <= 1'b0;
                    if (bus.bec_load_status == 3'd1) begin
                        dn  <= 1'b0;
                        mst <= 0;
                    end
                end
            endcase
        end
    end

    // Monitor: pops expectations whenever the controller presents output.
    always @(negedge clk) begin
        trig_t tr;
        res_t  rs;
        if (!rst) begin
            if (bus.bec_trig_load) begin
                if (trig_q.size() == 0) begin
                    chki("trig_unexpected", 1, 0);
                end else begin
                    tr = trig_q.pop_front();
                    chki("trig_status", int'(bus.bec_load_status), int'(tr.idx));
                    chk("trig_data", bus.bec_data_in, tr.d);
                    chki("trig_ki", int'(bus.bec_ki), int'(tr.ki));
                end
            end
            if (bus.done) begin
                if (res_q.size() == 0) begin
                    chki("done_unexpected", 1, 0);
                end else begin
                    rs = res_q.pop_front();
                    chki("res_err", int'(bus.err), int'(rs.err));
                    chk("res_x", bus.res_x, rs.x);
                    chk("res_z", bus.res_z, rs.z);
                end
            end
        end
    end

    task automatic feed(input int i, input logic [W-1:0] d);
        int t = 0;
        bus.op_data  = d;
        bus.op_valid = 1'b1;
        while (!bus.op_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chki("op_ready_timeout", t, 0);
        chki("op_idx", int'(bus.op_idx), i);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_idx(input int i);
        int t = 0;
        while (!(bus.op_ready && int'(bus.op_idx) == i) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chki("wait_idx_timeout", t, 0);
    endtask

    task automatic run(input logic [W-1:0] k, input int n, input bit c,
                       input bit stall, input bit dbl);
        logic [W-1:0] o [6];
        logic [W-1:0] kx;
        int t = 0;
        int bad = 0;
        res_t rs;
        trig_t tr;
        for (int i = 0; i < 6; i++) o[i] = rnd_w();
        kx = k >> (W - n);
        rs.err = (n != KEY_ITERS);
        rs.x = o[0] ^ o[1] ^ o[2] ^ kx;
        rs.z = o[3] ^ o[4] ^ o[5] ^ ~kx;
        res_q.push_back(rs);
        for (int i = 0; i < 6; i++) begin
            tr.idx = 3'(i);
            tr.d = o[i];
            tr.ki = k[W-1];
            trig_q.push_back(tr);
        end
        n_tgt = n;
        coin = c;
        bus.key = k;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (stall && i == 2) begin
                wait_idx(2);
                for (int j = 0; j < 50; j++) begin
                    @(negedge clk);
                    if (!bus.op_ready || bus.op_idx != 3'd2 || bus.bec_trig_load) bad++;
                end
                chki("stall_hold", bad, 0);
            end
            feed(i, o[i]);
        end
        if (dbl) begin
            repeat (20) @(negedge clk);
            bus.key = ~k;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        while ((res_q.size() != 0 || bus.busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chki("done_timeout", t, 0);
        chki("trig_q_drained", trig_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] k;
        int c_en;
        int c_dn;
        int bad;
        bus.start = 1'b0;
        bus.key = '0;
        bus.op_valid = 1'b0;
        bus.op_data = '0;
        bus2.start = 1'b0;
        bus2.key = '0;
        bus2.op_valid = 1'b1;
        bus2.op_data = {W{1'b1}};
        bus2.bec_status = 4'b0100;
        bus2.bec_next_key = 1'b0;
        bus2.bec_done = 1'b0;
        bus2.bec_data_out = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chki("rst_busy", int'(bus.busy), 0);
        chki("rst_done", int'(bus.done), 0);
        chki("rst_err", int'(bus.err), 0);
        chki("rst_op_ready", int'(bus.op_ready), 0);
        chki("rst_load_data", int'(bus.bec_load_data), 0);
        chki("rst_ki", int'(bus.bec_ki), 0);
        chk("rst_res_x", bus.res_x, '0);

        // Reset while waiting for operand 3.
        k = rnd_w();
        for (int i = 0; i < 3; i++) begin
            trig_t tr;
            tr.idx = 3'(i);
            tr.d = {W{1'b0}} | W'(i + 7);
            tr.ki = k[W-1];
            trig_q.push_back(tr);
        end
        bus.key = k;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) feed(i, {W{1'b0}} | W'(i + 7));
        wait_idx(3);
        chki("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chki("mid_rst_busy", int'(bus.busy), 0);
        chki("mid_rst_op_ready", int'(bus.op_ready), 0);
        chki("mid_rst_load_data", int'(bus.bec_load_data), 0);
        chki("mid_rst_trig_q", trig_q.size(), 0);
        trig_q.delete();
        rst = 1'b0;
        @(negedge clk);

        k = '0;
        k[W-1] = 1'b1;
        run(k, KEY_ITERS, 1'b0, 1'b0, 1'b0);
        run(rnd_w(), 100, 1'b0, 1'b0, 1'b0);
        chki("err_sticky", int'(bus.err), 1);
        run(rnd_w(), KEY_ITERS, 1'b0, 1'b1, 1'b0);
        chki("err_cleared", int'(bus.err), 0);
        run(rnd_w(), KEY_ITERS, 1'b1, 1'b0, 1'b1);
        run(rnd_w(), KEY_ITERS, 1'b0, 1'b0, 1'b0);

        // Watchdog instance: datapath never completes.
        bus2.key = rnd_w();
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        c_en = -1;
        c_dn = -1;
        bad = 0;
        for (int c = 0; c < 500 && c_dn < 0; c++) begin
            @(negedge clk);
            if (bus2.bec_enable) c_en = c;
            if (c_en >= 0 && bus2.bec_load_status != 3'd5) bad++;
            if (bus2.done) begin
                c_dn = c;
                chki("wd_err", int'(bus2.err), 1);
                chk("wd_res_x", bus2.res_x, '0);
            end
        end
        chki("wd_latency", c_dn - c_en, 65);
        chki("wd_no_upload", bad, 0);
        @(negedge clk);
        chki("wd_busy_clear", int'(bus2.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
